// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the multi-host device bus arbiter.
// Index widths, the outstanding-slot record and the default memory map.
package bus_arb_pkg;

  localparam int unsigned NrHostsDef   = 2;
  localparam int unsigned NrDevicesDef = 3;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned HostIdxW = idx_w(NrHostsDef);
  localparam int unsigned DevIdxW  = idx_w(NrDevicesDef);

  typedef struct packed {
    logic                valid;
    logic [HostIdxW-1:0] host_idx;
    logic [DevIdxW-1:0]  dev_idx;
    logic                unmapped;
  } outstanding_t;

  typedef enum int unsigned {
    DevRam     = 0,
    DevSimCtrl = 1,
    DevTimer   = 2
  } dev_e;

  localparam logic [31:0] RamBase     = 32'h0010_0000;
  localparam logic [31:0] RamMask     = 32'hFFF0_0000;
  localparam logic [31:0] SimCtrlBase = 32'h0002_0000;
  localparam logic [31:0] SimCtrlMask = 32'hFFFF_FC00;
  localparam logic [31:0] TimerBase   = 32'h0003_0000;
  localparam logic [31:0] TimerMask   = 32'hFFFF_FC00;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: first requester at or after the pointer.
// Purely combinational; the caller owns the pointer register.
module rr_arb_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Walk N slots from the pointer, wrapping, and take the first hit.
  always_comb begin
    int unsigned c;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = W'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Multi-host front end for the device bus: round-robin grant,
// base/mask decode, single outstanding slot and response routing.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts      = NrHostsDef,
  parameter int unsigned NrDevices    = NrDevicesDef,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);

  // The slot record is sized by the package; larger configs need a wider one.
  if (idx_w(NrHosts) > HostIdxW || idx_w(NrDevices) > DevIdxW) begin : g_cfg_chk
    $error("bus_host_arbiter: slot index fields too narrow");
  end

  outstanding_t          slot_q;
  logic [HostIdxW-1:0]   rr_ptr_q;
  logic [NrHosts-1:0]    pick_gnt;
  logic [HostIdxW-1:0]   win_idx;
  logic                  win_any;
  logic                  slot_done;
  logic                  can_grant;
  logic                  dev_hit;
  logic [DevIdxW-1:0]    dev_sel;
  logic [AddressWidth-1:0] win_addr;
  logic [NrDevices-1:0]  expect_rsp;

  // A response retires the slot; unmapped slots retire on their own.
  assign slot_done = slot_q.valid &
                     (slot_q.unmapped | device_rvalid_i[slot_q.dev_idx]);

  // Reset gates grants so every output reads 0 while rst_i is high.
  assign can_grant = ~rst_i & (~slot_q.valid | slot_done);

  rr_arb_pick #(
    .N (NrHosts),
    .W (HostIdxW)
  ) u_pick (
    .req_i (host_req_i & {NrHosts{can_grant}}),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign host_gnt_o = pick_gnt;
  assign win_addr   = host_addr_i[win_idx];

  // Address decode of the winner; descending scan leaves lowest hit.
  always_comb begin
    dev_hit = 1'b0;
    dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_hit = 1'b1;
        dev_sel = DevIdxW'(d);
      end
    end
  end

  // Forward the winner to its device only; idle devices see zeros.
  always_comb begin
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (win_any && dev_hit) begin
      device_req_o[dev_sel]   = 1'b1;
      device_addr_o[dev_sel]  = win_addr;
      device_we_o[dev_sel]    = host_we_i[win_idx];
      device_be_o[dev_sel]    = host_be_i[win_idx];
      device_wdata_o[dev_sel] = host_wdata_i[win_idx];
    end
  end

  // Route the completing response to the host that owns the slot.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (slot_done) begin
      host_rvalid_o[slot_q.host_idx] = 1'b1;
      host_err_o[slot_q.host_idx]    =
        slot_q.unmapped | device_err_i[slot_q.dev_idx];
      host_rdata_o[slot_q.host_idx]  =
        slot_q.unmapped ? '0 : device_rdata_i[slot_q.dev_idx];
    end
  end

  // Slot: load on grant, clear once the response has been delivered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else if (win_any) begin
      slot_q.valid    <= 1'b1;
      slot_q.host_idx <= win_idx;
      slot_q.dev_idx  <= dev_hit ? dev_sel : '0;
      slot_q.unmapped <= ~dev_hit;
    end else if (slot_done) begin
      slot_q <= '0;
    end
  end

  // Pointer moves past the winner on each grant, and only then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (win_any) begin
      rr_ptr_q <= (win_idx == HostIdxW'(NrHosts - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Which device, if any, is currently allowed to respond.
  always_comb begin
    expect_rsp = '0;
    if (slot_q.valid && !slot_q.unmapped) expect_rsp[slot_q.dev_idx] = 1'b1;
  end

  a_no_stray_rsp : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (device_rvalid_i & ~expect_rsp) == '0
  ) else $warning("bus_host_arbiter: stray device response dropped");

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: decode table, directed corner cases
// and a randomized run against a transaction-level reference model.
module tb_bus_host_arbiter;

  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic [NH-1:0]         host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [NH-1:0][AW-1:0] host_addr;
  logic [NH-1:0][BW-1:0] host_be;
  logic [NH-1:0][DW-1:0] host_wdata, host_rdata;
  logic [ND-1:0]         dev_req, dev_we, dev_rvalid, dev_err;
  logic [ND-1:0][AW-1:0] dev_addr, cfg_base, cfg_mask;
  logic [ND-1:0][BW-1:0] dev_be;
  logic [ND-1:0][DW-1:0] dev_wdata, dev_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts (NH), .NrDevices (ND), .DataWidth (DW), .AddressWidth (AW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .host_req_i           (host_req),
    .host_gnt_o           (host_gnt),
    .host_addr_i          (host_addr),
    .host_we_i            (host_we),
    .host_be_i            (host_be),
    .host_wdata_i         (host_wdata),
    .host_rvalid_o        (host_rvalid),
    .host_rdata_o         (host_rdata),
    .host_err_o           (host_err),
    .device_req_o         (dev_req),
    .device_addr_o        (dev_addr),
    .device_we_o          (dev_we),
    .device_be_o          (dev_be),
    .device_wdata_o       (dev_wdata),
    .device_rvalid_i      (dev_rvalid),
    .device_rdata_i       (dev_rdata),
    .device_err_i         (dev_err),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  typedef struct {
    logic [NH-1:0] req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [NH-1:0] gnt;
    logic [ND-1:0] dreq;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_req   = '0;
    host_addr  = '0;
    host_we    = '0;
    host_be    = '0;
    host_wdata = '0;
    dev_rvalid = '0;
    dev_err    = '0;
    dev_rdata  = '0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h0010_0000 + ($urandom & 32'h000F_FFFC);
      1:       return 32'h0002_0000 + ($urandom & 32'h0000_03FC);
      2:       return 32'h0003_0000 + ($urandom & 32'h0000_03FC);
      3:       return 32'h0005_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ND-1:0][AW-1:0] exp_daddr;
    logic [AW-1:0] wa;

    rst = 1'b1;
    idle();
    #1;
    chk("reset_gnt", host_gnt, 0);
    chk("reset_rvalid", {host_rvalid, host_err}, 0);
    chk("reset_dreq", dev_req, 0);
    chk("reset_daddr", dev_addr, 0);
    tick();
    rst = 1'b0;

    // Decode and pick table, pointer at 0; req dropped before each edge.
    tbl[0]  = '{2'b01, 32'h0010_0000, 32'h0,         2'b01, 3'b001};
    tbl[1]  = '{2'b10, 32'h0,         32'h0003_0004, 2'b10, 3'b100};
    tbl[2]  = '{2'b11, 32'h0002_0008, 32'h0010_0000, 2'b01, 3'b010};
    tbl[3]  = '{2'b01, 32'h0005_0000, 32'h0,         2'b01, 3'b000};
    tbl[4]  = '{2'b00, 32'h0010_0000, 32'h0010_0000, 2'b00, 3'b000};
    tbl[5]  = '{2'b10, 32'h0,         32'h001F_FFFC, 2'b10, 3'b001};
    tbl[6]  = '{2'b01, 32'h0020_0000, 32'h0,         2'b01, 3'b000};
    tbl[7]  = '{2'b01, 32'h0002_03FC, 32'h0,         2'b01, 3'b010};
    tbl[8]  = '{2'b01, 32'h0002_0400, 32'h0,         2'b01, 3'b000};
    tbl[9]  = '{2'b01, 32'h0003_0000, 32'h0,         2'b01, 3'b100};
    tbl[10] = '{2'b11, 32'h0005_0000, 32'h0010_0000, 2'b01, 3'b000};
    for (int i = 0; i < 11; i++) begin
      host_req     = tbl[i].req;
      host_addr[0] = tbl[i].a0;
      host_addr[1] = tbl[i].a1;
      #2;
      wa = tbl[i].gnt[0] ? tbl[i].a0 : tbl[i].a1;
      exp_daddr = '0;
      for (int d = 0; d < ND; d++) if (tbl[i].dreq[d]) exp_daddr[d] = wa;
      chk($sformatf("tbl%0d_gnt", i), host_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_dreq", i), dev_req, tbl[i].dreq);
      chk($sformatf("tbl%0d_daddr", i), dev_addr, exp_daddr);
      host_req = '0;
      tick();
    end

    // Two hosts streaming to RAM with a 1-cycle device.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      host_req     = 2'b11;
      host_addr[0] = 32'h0010_0000;
      host_addr[1] = 32'h0010_0010;
      dev_rvalid[0] = (k > 0);
      dev_rdata[0]  = 32'hA000 + k;
      #2;
      chk("alt_gnt", host_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_rvalid", host_rvalid,
          (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
      if (k > 0)
        chk("alt_rdata", host_rdata[(k % 2 == 1) ? 0 : 1], 32'hA000 + k);
      tick();
    end

    // Timer read by H1.
    do_reset();
    host_req     = 2'b10;
    host_addr[1] = 32'h0003_0004;
    #2;
    chk("tmr_gnt", host_gnt, 2'b10);
    chk("tmr_dreq", dev_req, 3'b100);
    chk("tmr_addr", dev_addr[2], 32'h0003_0004);
    tick();
    host_req      = '0;
    dev_rvalid[2] = 1'b1;
    dev_rdata[2]  = 32'hDEAD_BEEF;
    #2;
    chk("tmr_rvalid", host_rvalid, 2'b10);
    chk("tmr_rdata", host_rdata[1], 32'hDEAD_BEEF);
    chk("tmr_err", host_err & host_rvalid, 2'b00);
    chk("tmr_dreq_pulse", dev_req, 3'b000);
    tick();
    dev_rvalid = '0;

    // Unmapped access by H0 gets a local error response.
    do_reset();
    host_req     = 2'b01;
    host_addr[0] = 32'h0005_0000;
    dev_rdata[0] = 32'h1234_5678;
    #2;
    chk("unm_gnt", host_gnt, 2'b01);
    chk("unm_dreq", dev_req, 3'b000);
    tick();
    host_req = '0;
    #2;
    chk("unm_rvalid", host_rvalid, 2'b01);
    chk("unm_err", host_err & host_rvalid, 2'b01);
    chk("unm_rdata", host_rdata[0], 32'h0);
    tick();

    // RAM stalls for 5 cycles while both hosts keep requesting.
    do_reset();
    host_req     = 2'b11;
    host_addr[0] = 32'h0010_0000;
    host_addr[1] = 32'h0010_0004;
    #2;
    chk("stall_first_gnt", host_gnt, 2'b01);
    tick();
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_gnt", host_gnt, 2'b00);
      chk("stall_rvalid", host_rvalid, 2'b00);
      tick();
    end
    dev_rvalid[0] = 1'b1;
    #2;
    chk("stall_rsp_rvalid", host_rvalid, 2'b01);
    chk("stall_rsp_gnt", host_gnt, 2'b10);
    chk("stall_rsp_dreq", dev_req, 3'b001);
    tick();
    dev_rvalid = '0;

    // Reset with the slot valid and the pointer at 1.
    do_reset();
    host_req     = 2'b01;
    host_addr[0] = 32'h0010_0000;
    host_addr[1] = 32'h0010_0000;
    #2;
    chk("mid_gnt", host_gnt, 2'b01);
    tick();
    host_req      = 2'b11;
    dev_rvalid[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", host_gnt, 2'b00);
    chk("mid_rst_dreq", dev_req, 3'b000);
    chk("mid_rst_rvalid", {host_rvalid, host_err}, 0);
    chk("mid_rst_bus", {dev_addr, host_rdata}, 0);
    tick();
    rst = 1'b0;
    host_req = '0;
    #2;
    chk("post_rst_stray", host_rvalid, 2'b00);
    tick();
    dev_rvalid = '0;
    host_req   = 2'b11;
    #2;
    chk("post_rst_ptr", host_gnt, 2'b01);
    tick();

    // Overlapping regions: lowest device index wins.
    do_reset();
    cfg_base[0]  = 32'h0;
    cfg_mask[0]  = 32'h0;
    host_req     = 2'b01;
    host_addr[0] = 32'h0002_0000;
    #2;
    chk("ovl_dreq", dev_req, 3'b001);
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      int mptr, mhost, mdev, mlat, win, hitd;
      bit mbusy, munm, rsp, done;
      logic [NH-1:0] eg, erv, eer;
      logic [ND-1:0] edr;
      logic [NH-1:0][DW-1:0] erd, ard;
      mptr = 0; mbusy = 0; munm = 0; mhost = 0; mdev = 0; mlat = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int h = 0; h < NH; h++) begin
          host_req[h]   = ($urandom_range(0, 9) < 7);
          host_addr[h]  = rand_addr();
          host_we[h]    = $urandom_range(0, 1) == 1;
          host_be[h]    = BW'($urandom);
          host_wdata[h] = $urandom;
        end
        dev_rvalid = '0;
        dev_err    = '0;
        for (int d = 0; d < ND; d++) dev_rdata[d] = $urandom;
        rsp = mbusy && !munm && mlat == 0;
        if (rsp) begin
          dev_rvalid[mdev] = 1'b1;
          dev_err[mdev]    = ($urandom_range(0, 7) == 0);
        end
        done = mbusy && (munm || rsp);
        erv = '0; eer = '0; erd = '0;
        if (done) begin
          erv[mhost] = 1'b1;
          eer[mhost] = munm ? 1'b1 : dev_err[mdev];
          erd[mhost] = munm ? 32'h0 : dev_rdata[mdev];
        end
        win = -1;
        if (!mbusy || done)
          for (int i = 0; i < NH; i++)
            if (win < 0 && host_req[(mptr + i) % NH]) win = (mptr + i) % NH;
        eg = '0; edr = '0; hitd = -1;
        if (win >= 0) begin
          eg[win] = 1'b1;
          for (int d = 0; d < ND; d++)
            if (hitd < 0 && (host_addr[win] & cfg_mask[d]) == cfg_base[d])
              hitd = d;
          if (hitd >= 0) edr[hitd] = 1'b1;
        end
        #2;
        for (int h = 0; h < NH; h++)
          ard[h] = host_rvalid[h] ? host_rdata[h] : 32'h0;
        chk("rnd_gnt", host_gnt, eg);
        chk("rnd_dreq", dev_req, edr);
        chk("rnd_rvalid", host_rvalid, erv);
        chk("rnd_err", host_err & host_rvalid, eer);
        chk("rnd_rdata", ard, erd);
        if (hitd >= 0)
          chk("rnd_fwd",
              {dev_addr[hitd], dev_wdata[hitd], dev_be[hitd], dev_we[hitd]},
              {host_addr[win], host_wdata[win], host_be[win], host_we[win]});
        if (win >= 0) begin
          mbusy = 1;
          mhost = win;
          munm  = (hitd < 0);
          mdev  = (hitd < 0) ? 0 : hitd;
          mlat  = $urandom_range(0, 3);
          mptr  = (win + 1) % NH;
        end else if (done) begin
          mbusy = 0;
        end else if (mbusy && !munm) begin
          mlat--;
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
